// File: rtl/alu_pkg.sv
// Shared ALU definitions: divider FSM states, default divider width,
// {L,M,N} opcode encoding used by the control unit, and the quotient
// value reported for a zero divisor.
package alu_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } divState_t;

  localparam int DIV_WIDTH = 4;

  // Control-unit opcode field {L,M,N}
  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;
  localparam logic [2:0] OP_XOR = 3'b100;
  localparam logic [2:0] OP_DIV = 3'b101;
  localparam logic [2:0] OP_MUL = 3'b110;
  localparam logic [2:0] OP_NOP = 3'b111;

  localparam logic [DIV_WIDTH-1:0] DIV_ZERO_QUOTIENT = '1;

endpackage

// File: rtl/seq_divider_div_step.sv
// One restoring-division iteration: shift the next dividend bit into the
// partial remainder, trial-subtract the divisor at WIDTH+1 bits, and keep
// the difference only when it is non-negative.
module div_step #(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] remIn,
  input  logic             bitIn,
  input  logic [WIDTH-1:0] divisor,
  output logic [WIDTH-1:0] remOut,
  output logic             qBit
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;

  // Partial remainder is always below the divisor, so the shifted value
  // is below 2*divisor and a non-negative difference fits in WIDTH bits.
  always_comb begin
    shifted = {remIn, bitIn};
    diff    = shifted - {1'b0, divisor};
    qBit    = ~diff[WIDTH];
    remOut  = qBit ? diff[WIDTH-1:0] : shifted[WIDTH-1:0];
  end

endmodule

// File: rtl/seq_divider.sv
// Sequential restoring divider, one quotient bit per clock.
// Optional macro SEQ_DIVIDER_SIGNED_EN: two's-complement operands, handled
// as magnitudes with the signs reapplied on the final iteration.
// Handshake: start is taken only in IDLE or DONE (the accepting edge);
// busy is high while iterating; done is a one-cycle pulse marking valid
// quotient/remainder/div_by_zero, which hold until the next accepted start.
module seq_divider
  import alu_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic [1:0]       dbgState
);

  localparam int CW = $clog2(WIDTH + 1);

  divState_t        state, nextState;
  logic             accept;
  logic             lastStep;
  logic [CW-1:0]    count;
  logic             zeroDiv;
  logic [WIDTH-1:0] remReg, shiftReg, divisorReg;
  logic [WIDTH-1:0] stepRem;
  logic             stepQ;
  logic [WIDTH-1:0] rawQ, finalQ, finalR;
  logic [WIDTH-1:0] loadDividend, loadDivisor;

  assign rawQ     = {shiftReg[WIDTH-2:0], stepQ};
  assign lastStep = (state == S_RUN) && (count == CW'(1));

`ifdef SEQ_DIVIDER_SIGNED_EN
  logic dividendNeg, quotNeg;

  // A zero divisor reports the raw dividend, so no magnitude is taken then.
  assign loadDividend = (dividend[WIDTH-1] && (divisor != '0)) ? -dividend : dividend;
  assign loadDivisor  = divisor[WIDTH-1] ? -divisor : divisor;
  assign finalQ       = quotNeg ? -rawQ : rawQ;
  assign finalR       = dividendNeg ? -stepRem : stepRem;

  // Operand signs captured at accept for the final correction.
  always_ff @(posedge clk) begin
    if (rst) begin
      dividendNeg <= 1'b0;
      quotNeg     <= 1'b0;
    end else if (accept) begin
      dividendNeg <= dividend[WIDTH-1];
      quotNeg     <= dividend[WIDTH-1] ^ divisor[WIDTH-1];
    end
  end
`else
  assign loadDividend = dividend;
  assign loadDivisor  = divisor;
  assign finalQ       = rawQ;
  assign finalR       = stepRem;
`endif

  div_step #(.WIDTH(WIDTH)) uStep (
    .remIn  (remReg),
    .bitIn  (shiftReg[WIDTH-1]),
    .divisor(divisorReg),
    .remOut (stepRem),
    .qBit   (stepQ)
  );

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= nextState;
  end

  // Next-state logic; IDLE and DONE share the start-accept rule.
  always_comb begin
    nextState = state;
    accept    = 1'b0;
    case (state)
      S_IDLE, S_DONE: begin
        if (start) begin
          accept    = 1'b1;
          nextState = S_RUN;
        end else begin
          nextState = S_IDLE;
        end
      end
      S_RUN:   if (lastStep) nextState = S_DONE;
      default: nextState = S_IDLE;
    endcase
  end

  // Datapath: operand capture, iteration, and result registration. A zero
  // divisor spends a single RUN cycle with no iteration and then reports
  // the all-ones quotient and the untouched dividend.
  always_ff @(posedge clk) begin
    if (rst) begin
      count       <= '0;
      zeroDiv     <= 1'b0;
      remReg      <= '0;
      shiftReg    <= '0;
      divisorReg  <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      zeroDiv     <= (divisor == '0);
      count       <= (divisor == '0) ? CW'(1) : CW'(WIDTH);
      remReg      <= '0;
      shiftReg    <= loadDividend;
      divisorReg  <= loadDivisor;
      div_by_zero <= 1'b0;
    end else if (state == S_RUN) begin
      count    <= count - CW'(1);
      remReg   <= stepRem;
      shiftReg <= rawQ;
      if (lastStep) begin
        if (zeroDiv) begin
          quotient    <= '1;
          remainder   <= shiftReg;
          div_by_zero <= 1'b1;
        end else begin
          quotient    <= finalQ;
          remainder   <= finalR;
        end
      end
    end
  end

  assign busy     = (state == S_RUN);
  assign done     = (state == S_DONE);
  assign dbgState = state;

endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed scenarios plus randomized operands
// checked against a plain-arithmetic division model.
module tb_seq_divider;
  import alu_pkg::*;

  localparam int W = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] dividend, divisor;
  logic         busy, done;
  logic [W-1:0] quotient, remainder;
  logic         div_by_zero;
  logic [1:0]   dbgState;

  int vectors = 0;
  int miscompares = 0;

  seq_divider #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .dividend(dividend), .divisor(divisor),
    .busy(busy), .done(done),
    .quotient(quotient), .remainder(remainder),
    .div_by_zero(div_by_zero), .dbgState(dbgState)
  );

  // Clock
  always #5 clk = ~clk;

  // Reference model: ordinary integer division.
  function automatic void model(input logic [W-1:0] a, input logic [W-1:0] b,
                                output logic [W-1:0] q, output logic [W-1:0] r,
                                output logic z);
    if (b == '0) begin
      q = '1;
      r = a;
      z = 1'b1;
    end else begin
`ifdef SEQ_DIVIDER_SIGNED_EN
      int sa, sb;
      sa = int'($signed(a));
      sb = int'($signed(b));
      q = W'(sa / sb);
      r = W'(sa % sb);
`else
      q = W'(int'(a) / int'(b));
      r = W'(int'(a) % int'(b));
`endif
      z = 1'b0;
    end
  endfunction

  // Driver: present operands with start, wait for done (bounded). Returns
  // edges from accept to done, busy just after the accept edge, results.
  // Returns #1 after the done edge, so an immediate next call is back-to-back.
  task automatic run_div(input logic [W-1:0] a, input logic [W-1:0] b,
                         input bit pulse_busy, output int lat, output logic busy_k,
                         output logic [W-1:0] q, output logic [W-1:0] r,
                         output logic z);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    dividend = W'($urandom);
    divisor  = W'($urandom);
    busy_k   = busy;
    lat      = 0;
    for (int n = 1; n <= W + 4; n++) begin
      if (pulse_busy && busy) begin
        start    = 1'b1;
        dividend = W'($urandom);
        divisor  = W'($urandom);
      end
      @(posedge clk);
      #1;
      start = 1'b0;
      if (done) begin
        lat = n;
        break;
      end
    end
    if (lat == 0) begin
      vectors++;
      miscompares++;
      $display("FAIL done_timeout: no done within %0d edges for %0d/%0d", W + 4, a, b);
    end
    q = quotient;
    r = remainder;
    z = div_by_zero;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL reset_done: got %b want 0", done); end
    vectors++; if (quotient !== '0) begin miscompares++; $display("FAIL reset_quotient: got %h want 0", quotient); end
    vectors++; if (remainder !== '0) begin miscompares++; $display("FAIL reset_remainder: got %h want 0", remainder); end
    vectors++; if (div_by_zero !== 1'b0) begin miscompares++; $display("FAIL reset_dbz: got %b want 0", div_by_zero); end
    vectors++; if (dbgState !== 2'(S_IDLE)) begin miscompares++; $display("FAIL reset_state: got %0d want %0d", dbgState, S_IDLE); end
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_basic();
    int lat; logic bk, z, ez; logic [W-1:0] q, r, eq, er;
    run_div(4'd13, 4'd3, 1'b0, lat, bk, q, r, z);
    model(4'd13, 4'd3, eq, er, ez);
    vectors++; if (bk !== 1'b1) begin miscompares++; $display("FAIL basic_busy: got %b want 1", bk); end
    vectors++; if (lat != W) begin miscompares++; $display("FAIL basic_latency: got %0d want %0d", lat, W); end
    vectors++; if (q !== eq) begin miscompares++; $display("FAIL basic_quotient: got %h want %h", q, eq); end
    vectors++; if (r !== er) begin miscompares++; $display("FAIL basic_remainder: got %h want %h", r, er); end
    vectors++; if (z !== ez) begin miscompares++; $display("FAIL basic_dbz: got %b want %b", z, ez); end
    @(posedge clk);
    #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL basic_done_pulse: got %b want 0", done); end
    vectors++; if (quotient !== eq) begin miscompares++; $display("FAIL basic_hold: got %h want %h", quotient, eq); end
  endtask

  task automatic test_div_zero();
    int lat; logic bk, z, ez; logic [W-1:0] q, r, eq, er;
    @(posedge clk);
    #1;
    run_div(4'd7, 4'd0, 1'b0, lat, bk, q, r, z);
    vectors++; if (lat != 1) begin miscompares++; $display("FAIL dbz_latency: got %0d want 1", lat); end
    vectors++; if (q !== 4'b1111) begin miscompares++; $display("FAIL dbz_quotient: got %h want f", q); end
    vectors++; if (r !== 4'd7) begin miscompares++; $display("FAIL dbz_remainder: got %h want 7", r); end
    vectors++; if (z !== 1'b1) begin miscompares++; $display("FAIL dbz_flag: got %b want 1", z); end
    @(posedge clk);
    #1;
    run_div(4'd8, 4'd2, 1'b0, lat, bk, q, r, z);
    model(4'd8, 4'd2, eq, er, ez);
    vectors++; if (z !== 1'b0) begin miscompares++; $display("FAIL dbz_clear: got %b want 0", z); end
    vectors++; if (q !== eq) begin miscompares++; $display("FAIL dbz_next_quotient: got %h want %h", q, eq); end
    vectors++; if (r !== er) begin miscompares++; $display("FAIL dbz_next_remainder: got %h want %h", r, er); end
  endtask

  task automatic test_ignore_start();
    int lat; logic bk, z, ez; logic [W-1:0] q, r, eq, er;
    logic [W-1:0] av[2], bv[2];
    av[0] = 4'd5;  bv[0] = 4'd9;
    av[1] = 4'd15; bv[1] = 4'd1;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      run_div(av[i], bv[i], 1'b1, lat, bk, q, r, z);
      model(av[i], bv[i], eq, er, ez);
      vectors++; if (lat != W) begin miscompares++; $display("FAIL ignore_latency[%0d]: got %0d want %0d", i, lat, W); end
      vectors++; if (q !== eq) begin miscompares++; $display("FAIL ignore_quotient[%0d]: got %h want %h", i, q, eq); end
      vectors++; if (r !== er) begin miscompares++; $display("FAIL ignore_remainder[%0d]: got %h want %h", i, r, er); end
      @(posedge clk);
      #1;
      vectors++; if (dbgState !== 2'(S_IDLE)) begin miscompares++; $display("FAIL ignore_idle[%0d]: got %0d want %0d", i, dbgState, S_IDLE); end
    end
  endtask

  task automatic test_back_to_back();
    int lat; logic bk, z, ez; logic [W-1:0] q, r, eq, er;
    run_div(4'd11, 4'd4, 1'b0, lat, bk, q, r, z);
    run_div(4'd12, 4'd5, 1'b0, lat, bk, q, r, z);
    model(4'd12, 4'd5, eq, er, ez);
    vectors++; if (lat != W) begin miscompares++; $display("FAIL b2b_latency: got %0d want %0d", lat, W); end
    vectors++; if (q !== eq) begin miscompares++; $display("FAIL b2b_quotient: got %h want %h", q, eq); end
    vectors++; if (r !== er) begin miscompares++; $display("FAIL b2b_remainder: got %h want %h", r, er); end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid();
    int lat; logic bk, z, ez; logic [W-1:0] q, r, eq, er;
    dividend = 4'd14;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL midrst_busy: got %b want 0", busy); end
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_done: got %b want 0", done); end
    vectors++; if (quotient !== '0 || remainder !== '0) begin miscompares++; $display("FAIL midrst_results: got %h/%h want 0/0", quotient, remainder); end
    vectors++; if (dbgState !== 2'(S_IDLE)) begin miscompares++; $display("FAIL midrst_state: got %0d want %0d", dbgState, S_IDLE); end
    repeat (W) @(posedge clk);
    #1;
    vectors++; if (done !== 1'b0) begin miscompares++; $display("FAIL midrst_stale_done: got %b want 0", done); end
    run_div(4'd9, 4'd4, 1'b0, lat, bk, q, r, z);
    model(4'd9, 4'd4, eq, er, ez);
    vectors++; if (q !== eq) begin miscompares++; $display("FAIL midrst_quotient: got %h want %h", q, eq); end
    vectors++; if (r !== er) begin miscompares++; $display("FAIL midrst_remainder: got %h want %h", r, er); end
  endtask

`ifdef SEQ_DIVIDER_SIGNED_EN
  task automatic test_signed();
    int lat; logic bk, z;
    logic [W-1:0] q, r;
    logic [W-1:0] av[3], bv[3], eqv[3], erv[3];
    av[0] = 4'b1001; bv[0] = 4'd2;    eqv[0] = 4'b1101; erv[0] = 4'b1111;
    av[1] = 4'b1000; bv[1] = 4'b1111; eqv[1] = 4'b1000; erv[1] = 4'b0000;
    av[2] = 4'd7;    bv[2] = 4'b1110; eqv[2] = 4'b1101; erv[2] = 4'b0001;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      run_div(av[i], bv[i], 1'b0, lat, bk, q, r, z);
      vectors++; if (lat != W) begin miscompares++; $display("FAIL signed_latency[%0d]: got %0d want %0d", i, lat, W); end
      vectors++; if (q !== eqv[i]) begin miscompares++; $display("FAIL signed_quotient[%0d]: got %b want %b", i, q, eqv[i]); end
      vectors++; if (r !== erv[i]) begin miscompares++; $display("FAIL signed_remainder[%0d]: got %b want %b", i, r, erv[i]); end
    end
  endtask
`endif

  task automatic test_random();
    int lat, gap; logic bk, z, ez; logic [W-1:0] a, b, q, r, eq, er;
    for (int i = 0; i < 60; i++) begin
      a = W'($urandom);
      b = ($urandom_range(0, 7) == 0) ? '0 : W'($urandom);
      gap = $urandom_range(0, 2);
      repeat (gap) @(posedge clk);
      if (gap != 0) #1;
      run_div(a, b, 1'b0, lat, bk, q, r, z);
      model(a, b, eq, er, ez);
      vectors++; if (lat != ((b == '0) ? 1 : W)) begin miscompares++; $display("FAIL rand_latency[%0d]: %0d/%0d got %0d", i, a, b, lat); end
      vectors++; if (q !== eq) begin miscompares++; $display("FAIL rand_quotient[%0d]: %0d/%0d got %h want %h", i, a, b, q, eq); end
      vectors++; if (r !== er) begin miscompares++; $display("FAIL rand_remainder[%0d]: %0d/%0d got %h want %h", i, a, b, r, er); end
      vectors++; if (z !== ez) begin miscompares++; $display("FAIL rand_dbz[%0d]: %0d/%0d got %b want %b", i, a, b, z, ez); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_div_zero();
    test_ignore_start();
    test_back_to_back();
    test_reset_mid();
`ifdef SEQ_DIVIDER_SIGNED_EN
    test_signed();
`endif
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/seq_divider.md
Name: seq_divider

Overview:
Sequential restoring divider for the ALU datapath. It is the inverse counterpart of the planned multiply path: it takes a dividend/divisor pair and produces quotient and remainder over WIDTH iterations, one bit per clock. It sits beside the combinational ALU and is selected by the control unit for division opcodes, using a start/done handshake.

Parameters:
WIDTH, 4, operand/result width in bits (≥2)

Ports:
clk  input  1  rising-edge clock
rst  input  1  synchronous, active-high reset
start  input  1  request; sampled only in IDLE or DONE state
dividend  input  WIDTH  dividend, captured on accepted start
divisor  input  WIDTH  divisor, captured on accepted start
busy  output  1  high while iterating
done  output  1  one-cycle pulse: results valid
quotient  output  WIDTH  quotient, held until next accepted start
remainder  output  WIDTH  remainder, held until next accepted start
div_by_zero  output  1  set with done when divisor was 0; held with results

Behaviour:
- Reset: all outputs 0, state IDLE, iteration counter 0. Reset wins over every other event, including mid-operation; a partial result is discarded.
- States: IDLE, RUN, DONE.
- IDLE: start=1 at edge k accepts the operands. If divisor≠0, go to RUN with counter=WIDTH, partial remainder=0, shift register=dividend; busy=1 from edge k.
- RUN: each edge shifts {rem,shift} left 1. The block does trial subtraction rem−divisor at WIDTH+1 bits. If the result is non-negative, rem takes the difference and the quotient LSB is 1; otherwise rem is restored and the LSB is 0. Counter decrements each edge. At edge k+WIDTH, results are registered, busy=0, and state goes to DONE.
- DONE: done=1 for exactly this one cycle. The next edge goes to IDLE, or accepts a new start directly (back-to-back, same rules as IDLE).
- Latency: done is high in the cycle after edge k+WIDTH. With WIDTH=4, done is high 4 cycles after the start edge.
- start while busy is ignored with no effect. Operand inputs are don't-care except at an accepted start.
- Divide by zero (divisor=0 at accept): no RUN. DONE is entered at edge k+1 with quotient = all ones, remainder = dividend, div_by_zero=1.
- div_by_zero clears on the next accepted start.
- Unsigned arithmetic. Results are always exact: dividend = quotient·divisor + remainder, with remainder < divisor.

Optional Feature:
SEQ_DIVIDER_SIGNED_EN
- Defined: operands are two's complement. At accept, magnitudes are taken and the signs are stored. At the final edge, signs are applied:
  - quotient is negative iff the operand signs differ;
  - remainder takes the dividend's sign.
- Overflow case (most-negative / −1) yields quotient = most-negative (wraps) and remainder 0. There is no extra flag.
- Divide-by-zero result is unchanged: quotient = all ones, remainder = raw dividend.
- Latency is identical to unsigned.
- Undefined: unsigned only, and no sign logic is synthesised.

Decomposition:
- alu_pkg holds:
  - state enum (IDLE/RUN/DONE);
  - DIV_WIDTH default 4;
  - ALU opcode constants for the L,M,N control encoding, including the divide opcode;
  - divide-by-zero quotient constant (all ones).
- One combinational sub-module, div_step: takes partial remainder, next dividend bit and divisor; returns the new remainder and the quotient bit. It is instantiated once in the RUN datapath.

Test Plan:
- 13/3 unsigned, start at edge k → busy edges k..k+4; done high one cycle after edge k+4; quotient=4, remainder=1, div_by_zero=0.
- 7/0 → done after edge k+1; quotient=4'b1111, remainder=7, div_by_zero=1. A following 8/2 clears the flag → quotient=4, remainder=0.
- 5/9 → quotient=0, remainder=5. Then 15/1 → quotient=15, remainder=0. Start pulses issued during busy are ignored, and results match the first operands only.
- Back-to-back: start=1 during the DONE cycle with 12/5 → accepted; quotient=2, remainder=2 after WIDTH further edges.
- rst=1 at edge k+2 of 14/3 → next cycle all outputs 0, state IDLE. A fresh 9/4 then completes normally → quotient=2, remainder=1.
- SEQ_DIVIDER_SIGNED_EN defined:
  - −7/2 → quotient=4'b1101, remainder=4'b1111;
  - −8/−1 → quotient=4'b1000, remainder=0;
  - 7/−2 → quotient=4'b1101, remainder=1.
